// File: rtl/registrador_16b_if.sv
// Bus bundle for the parallel-load datapath register: load request in, stored word and status out.
interface registrador_16b_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] entrada;
    logic             load;
    logic [WIDTH-1:0] saida;
    logic             zero;
    logic             carregado;

    modport master (
        output entrada,
        output load,
        input  saida,
        input  zero,
        input  carregado
    );

    modport slave (
        input  entrada,
        input  load,
        output saida,
        output zero,
        output carregado
    );
endinterface

// File: rtl/registrador_16b.sv
// General-purpose parallel-load register with zero flag and one-cycle load-done pulse.
module registrador_16b #(
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic               clk,
    input logic               rst_n,
    registrador_16b_if.slave  bus
);
    logic [WIDTH-1:0] saida_q;
    logic             carregado_q;

    // Storage and load-done flag; reset wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q     <= RESET_VALUE;
            carregado_q <= 1'b0;
        end else begin
            if (bus.load) begin
                saida_q <= bus.entrada;
            end
            carregado_q <= bus.load;
        end
    end

    assign bus.saida     = saida_q;
    assign bus.carregado = carregado_q;
    // Zero flag decodes only the stored word, never entrada.
    assign bus.zero      = (saida_q == WIDTH'(0));
endmodule

// File: tb/tb_registrador_16b.sv
// Scoreboard bench for registrador_16b: model results queued on drive, compared after each edge.
module tb_registrador_16b;
    localparam int unsigned WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] saida;
        logic             carregado;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    registrador_16b_if #(.WIDTH(WIDTH)) bus ();

    registrador_16b #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned      n_vec = 0;
    int unsigned      n_err = 0;
    exp_t             exp_q[$];
    logic [WIDTH-1:0] mdl_saida = '0;
    logic             mdl_carr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_saida"},     32'(bus.saida),     32'(e.saida));
        check_eq({tag, "_carregado"}, 32'(bus.carregado), 32'(e.carregado));
        check_eq({tag, "_zero"},      32'(bus.zero),      32'(e.zero));
    endtask

    // Drive at the falling edge, queue the model result, compare just after the rising edge.
    task automatic apply(input string tag, input logic [WIDTH-1:0] d, input logic ld);
        exp_t e;
        @(negedge clk);
        bus.entrada = d;
        bus.load    = ld;
        if (ld) mdl_saida = d;
        mdl_carr    = ld;
        e.saida     = mdl_saida;
        e.carregado = mdl_carr;
        e.zero      = (mdl_saida == '0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Async reset with load pending and no clock edge yet.
        rst_n       = 1'b0;
        bus.entrada = 16'hFFFF;
        bus.load    = 1'b1;
        #2;
        check_eq("rst_saida",     32'(bus.saida),     32'h0);
        check_eq("rst_zero",      32'(bus.zero),      32'h1);
        check_eq("rst_carregado", 32'(bus.carregado), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.load = 1'b0;

        apply("hold0", 16'h0000, 1'b0);
        apply("hold1", 16'h0001, 1'b0);
        apply("load1", 16'h0001, 1'b1);
        apply("after_load", 16'h0000, 1'b0);

        // Toggle entrada while clk is high: no edge, no change.
        @(posedge clk);
        #1;
        bus.load = 1'b1;
        foreach (bus.entrada[i]) ;
        bus.entrada = 16'hAAAA; #1;
        check_eq("between_aaaa", 32'(bus.saida), 32'(mdl_saida));
        bus.entrada = 16'h5555; #1;
        check_eq("between_5555", 32'(bus.saida), 32'(mdl_saida));
        bus.entrada = 16'h0000; #1;
        check_eq("between_0000", 32'(bus.saida), 32'(mdl_saida));
        apply("edge_after_toggle", 16'h5555, 1'b1);

        apply("b2b_1234", 16'h1234, 1'b1);
        apply("b2b_ffff", 16'hFFFF, 1'b1);
        apply("b2b_0000", 16'h0000, 1'b1);
        apply("same_value", 16'h0000, 1'b1);
        apply("idle", 16'hC3C3, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom);
            apply("rand", v, 1'($urandom_range(0, 1)));
        end

        // Mid-cycle reset after loading BEEF.
        apply("load_beef", 16'hBEEF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_saida",     32'(bus.saida),     32'h0);
        check_eq("midrst_carregado", 32'(bus.carregado), 32'h0);
        check_eq("midrst_zero",      32'(bus.zero),      32'h1);
        mdl_saida = '0;
        mdl_carr  = 1'b0;
        #1;
        rst_n = 1'b1;
        apply("post_rst_00ff", 16'h00FF, 1'b1);
        apply("post_rst_hold", 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/registrador_16b.md
Name: registrador_16b

Overview:
- General-purpose parallel-load data register (default 16 bits) for the datapath of the course processor project.
- Captures `entrada` on a rising clock edge when `load` is high; otherwise holds its value.
- Drives the stored word continuously on `saida`, plus two status outputs for the control unit: a zero flag and a load-done pulse.

Parameters:
- WIDTH, 16, data width in bits of `entrada` and `saida` (legal values ≥ 1).
- RESET_VALUE, 0, value loaded into the register on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entrada  input  WIDTH  parallel data input.
- load  input  1  load enable, active high, sampled at the rising edge of clk.
- saida  output  WIDTH  registered stored value.
- zero  output  1  high when saida == 0.
- carregado  output  1  registered pulse; high for the one cycle following an accepted load.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). Both are fixed.
- Reset:
  - rst_n low immediately forces saida = RESET_VALUE and carregado = 0, independent of clk.
  - Reset overrides load.
  - zero follows saida (1 when RESET_VALUE == 0).
  - Deassertion is not synchronised inside the block; the top level provides a synchronised rst_n.
- Load, at each rising clk edge with rst_n high:
  - load == 1: saida <= entrada (all WIDTH bits). Latency is 1 edge; the new value is visible right after that edge.
  - load == 0: saida holds its value.
  - carregado <= load, so it is high during the cycle after each edge where load was 1. Back-to-back loads keep carregado high continuously.
- No combinational path from entrada or load to saida or carregado.
- Changes on entrada or load between edges have no effect.
- Loading a value equal to the current contents is a normal load: saida is unchanged and carregado still pulses.
- zero is combinational from the saida register only: zero = (saida == 0). It contains no logic on entrada.
- Reset asserted mid-cycle clears saida and carregado immediately. The first load is accepted at the first rising edge after rst_n goes high.
- Simultaneous rising edge and reset release: no load is guaranteed on that edge; the bench must not rely on it.
- No X propagation from uninitialised state; after reset all outputs are defined.

Test Plan:
- Reset: rst_n = 0 with entrada = 16'hFFFF and load = 1 -> saida = 0, zero = 1, carregado = 0, with no clock edge required.
- Hold: rst_n = 1, entrada = 0, load = 0, rising edge -> saida = 0, carregado = 0. Then entrada = 16'h0001 with load = 0, edge -> saida stays 0.
- Load: entrada = 16'h0001, load = 1 set before the edge (clk low), rising edge -> saida = 16'h0001, zero = 0, carregado = 1 for one cycle. Then load = 0, entrada = 0, edge -> saida stays 16'h0001, carregado = 0.
- Between-edge stimulus: toggle entrada among 16'hAAAA, 16'h5555 and 16'h0000 with load = 1 but no clk edge -> saida unchanged. At the next edge saida equals the entrada present at that edge.
- Back-to-back loads: 16'h1234, 16'hFFFF and 16'h0000 on consecutive edges with load = 1 -> saida follows each value one edge later, carregado stays high, zero rises after the 16'h0000 load.
- Mid-operation reset: after saida = 16'hBEEF, pulse rst_n low between edges -> saida = 0 immediately. After release, entrada = 16'h00FF with load = 1 -> saida = 16'h00FF at the next edge.
